// File: rtl/caliptra_fpga_sync_timebase_if.sv
`default_nettype none
// ============================================================================
// Module   : caliptra_fpga_sync_timebase_if
// Brief    : Register-block side bundle for the sync timebase (hwif fields).
// Revision : 1.0  initial release
// ============================================================================
interface caliptra_fpga_sync_timebase_if #(
    parameter int CNT_W      = 64,
    parameter int NUM_CH     = 4,
    parameter int PRESCALE_W = 16
);
    logic                    en;
    logic [PRESCALE_W-1:0]   prescale;
    logic                    load_valid;
    logic [CNT_W-1:0]        load_value;
    logic [CNT_W-1:0]        count;
    logic                    wrap;
    logic                    snap_req;
    logic [CNT_W-1:0]        snap_value;
    logic                    snap_valid;
    logic [NUM_CH-1:0]       cmp_arm;
    logic [NUM_CH-1:0]       cmp_disarm;
    logic [NUM_CH*CNT_W-1:0] cmp_value;
    logic [NUM_CH*CNT_W-1:0] cmp_period;
    logic [NUM_CH-1:0]       cmp_armed;
    logic [NUM_CH-1:0]       cmp_hit;
    logic [NUM_CH-1:0]       hit_clr;
    logic [NUM_CH-1:0]       cap_in;
    logic [NUM_CH-1:0]       cap_clr;
    logic [NUM_CH*CNT_W-1:0] cap_value;
    logic [NUM_CH-1:0]       cap_valid;
    logic [NUM_CH-1:0]       cap_overrun;
    logic                    irq;

    modport master (
        output en, prescale, load_valid, load_value, snap_req,
               cmp_arm, cmp_disarm, cmp_value, cmp_period, hit_clr,
               cap_in, cap_clr,
        input  count, wrap, snap_value, snap_valid, cmp_armed, cmp_hit,
               cap_value, cap_valid, cap_overrun, irq
    );

    modport slave (
        input  en, prescale, load_valid, load_value, snap_req,
               cmp_arm, cmp_disarm, cmp_value, cmp_period, hit_clr,
               cap_in, cap_clr,
        output count, wrap, snap_value, snap_valid, cmp_armed, cmp_hit,
               cap_value, cap_valid, cap_overrun, irq
    );
endinterface
`default_nettype wire

// File: rtl/caliptra_fpga_sync_timebase.sv
`default_nettype none
// ============================================================================
// Module   : caliptra_fpga_sync_timebase
// Brief    : Prescaled free-running counter with load, snapshot and NUM_CH
//            compare/capture channels feeding a single irq.
// Revision : 1.0  initial release
// ============================================================================
module caliptra_fpga_sync_timebase #(
    parameter int CNT_W      = 64,
    parameter int NUM_CH     = 4,
    parameter int PRESCALE_W = 16
) (
    input  logic                          aclk,
    input  logic                          rst,
    caliptra_fpga_sync_timebase_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Counter datapath
    // ------------------------------------------------------------------
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wrap;
    logic [CNT_W-1:0]      r_snap_value;
    logic                  r_snap_valid;
    logic                  r_irq;

    logic                  w_tick;
    logic                  w_update;
    logic [CNT_W-1:0]      w_count_inc;
    logic [CNT_W-1:0]      w_next_count;

    // ------------------------------------------------------------------
    // Channel state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]      r_target    [NUM_CH];
    logic [CNT_W-1:0]      r_cap_value [NUM_CH];
    logic [NUM_CH-1:0]     r_armed;
    logic [NUM_CH-1:0]     r_hit;
    logic [NUM_CH-1:0]     r_cap_valid;
    logic [NUM_CH-1:0]     r_cap_overrun;
    logic [NUM_CH-1:0]     r_sync1;
    logic [NUM_CH-1:0]     r_sync2;
    logic [NUM_CH-1:0]     r_sync3;
    logic [1:0]            r_warm;

    logic [NUM_CH-1:0]     w_hit_evt;
    logic [NUM_CH-1:0]     w_cap_edge;
    logic                  w_warm;
    logic [NUM_CH*CNT_W-1:0] w_cap_value_flat;

    // A prescale lowered below the running pcnt ticks immediately (>=, not ==).
    assign w_tick       = bus.en & (r_pcnt >= bus.prescale);
    assign w_update     = bus.load_valid | w_tick;
    assign w_count_inc  = r_count + c_ONE;
    assign w_next_count = bus.load_valid ? bus.load_value : w_count_inc;

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_pcnt       <= '0;
            r_count      <= '0;
            r_wrap       <= 1'b0;
            r_snap_value <= '0;
            r_snap_valid <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (bus.load_valid) begin
                r_count <= bus.load_value;
                r_pcnt  <= '0;
            end else if (w_tick) begin
                r_count <= w_count_inc;
                r_pcnt  <= '0;
            end else if (bus.en) begin
                r_pcnt  <= r_pcnt + 1'b1;
            end

            r_wrap <= ~bus.load_valid & w_tick & (w_count_inc == '0);

            if (bus.snap_req) begin
                r_snap_value <= r_count;
            end
            r_snap_valid <= bus.snap_req;

            r_irq <= |(r_hit | r_cap_valid);
        end
    end

    // Post-reset warm-up: the synchroniser must hold three genuine samples
    // before an edge is believed, so a strobe held high through reset is
    // seen as a steady level rather than a rising edge.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_warm <= 2'd0;
        end else if (r_warm != 2'd3) begin
            r_warm <= r_warm + 2'd1;
        end
    end

    assign w_warm = (r_warm == 2'd3);

    // Arm and disarm both pre-empt a same-cycle hit on that channel.
    always_comb begin
        w_hit_evt  = '0;
        w_cap_edge = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_hit_evt[c]  = r_armed[c] & w_update & (w_next_count == r_target[c])
                          & ~bus.cmp_arm[c] & ~bus.cmp_disarm[c];
            w_cap_edge[c] = r_sync2[c] & ~r_sync3[c] & w_warm;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_armed       <= '0;
            r_hit         <= '0;
            r_cap_valid   <= '0;
            r_cap_overrun <= '0;
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_sync3       <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_target[c]    <= '0;
                r_cap_value[c] <= '0;
            end
        end else begin
            r_sync1 <= bus.cap_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.cmp_arm[c]) begin
                    r_target[c] <= bus.cmp_value[c*CNT_W +: CNT_W];
                    r_armed[c]  <= 1'b1;
                end else if (bus.cmp_disarm[c]) begin
                    r_armed[c]  <= 1'b0;
                end else if (w_hit_evt[c]) begin
                    if (bus.cmp_period[c*CNT_W +: CNT_W] != '0) begin
                        r_target[c] <= r_target[c] + bus.cmp_period[c*CNT_W +: CNT_W];
                    end else begin
                        r_armed[c]  <= 1'b0;
                    end
                end

                if (w_hit_evt[c]) begin
                    r_hit[c] <= 1'b1;
                end else if (bus.hit_clr[c]) begin
                    r_hit[c] <= 1'b0;
                end

                // An edge coinciding with cap_clr starts a fresh capture.
                if (w_cap_edge[c] & (~r_cap_valid[c] | bus.cap_clr[c])) begin
                    r_cap_value[c]   <= r_count;
                    r_cap_valid[c]   <= 1'b1;
                    r_cap_overrun[c] <= 1'b0;
                end else if (w_cap_edge[c]) begin
                    r_cap_overrun[c] <= 1'b1;
                end else if (bus.cap_clr[c]) begin
                    r_cap_valid[c]   <= 1'b0;
                    r_cap_overrun[c] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cap_flat
        assign w_cap_value_flat[g*CNT_W +: CNT_W] = r_cap_value[g];
    end

    assign bus.count       = r_count;
    assign bus.wrap        = r_wrap;
    assign bus.snap_value  = r_snap_value;
    assign bus.snap_valid  = r_snap_valid;
    assign bus.cmp_armed   = r_armed;
    assign bus.cmp_hit     = r_hit;
    assign bus.cap_value   = w_cap_value_flat;
    assign bus.cap_valid   = r_cap_valid;
    assign bus.cap_overrun = r_cap_overrun;
    assign bus.irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_caliptra_fpga_sync_timebase.sv
`default_nettype none
// ============================================================================
// Module   : tb_caliptra_fpga_sync_timebase
// Brief    : Randomised + directed bench with a behavioural model and scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_caliptra_fpga_sync_timebase;
    parameter int CNT_W      = 16;
    parameter int NUM_CH     = 4;
    parameter int PRESCALE_W = 4;

    localparam logic [CNT_W-1:0] c_MAX = '1;

    typedef struct packed {
        logic [CNT_W-1:0]        count;
        logic                    wrap;
        logic [CNT_W-1:0]        snap_value;
        logic                    snap_valid;
        logic [NUM_CH-1:0]       armed;
        logic [NUM_CH-1:0]       hit;
        logic [NUM_CH*CNT_W-1:0] cap_value;
        logic [NUM_CH-1:0]       cap_valid;
        logic [NUM_CH-1:0]       cap_ovr;
        logic                    irq;
    } exp_t;

    logic aclk;
    logic rst;

    caliptra_fpga_sync_timebase_if #(
        .CNT_W(CNT_W), .NUM_CH(NUM_CH), .PRESCALE_W(PRESCALE_W)
    ) bus ();

    caliptra_fpga_sync_timebase #(
        .CNT_W(CNT_W), .NUM_CH(NUM_CH), .PRESCALE_W(PRESCALE_W)
    ) dut (
        .aclk (aclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_pass  = 0;
    int n_total = 0;

    exp_t             q[$];
    logic [CNT_W-1:0] snap_q[$];

    // Behavioural model state
    logic [CNT_W-1:0]  m_count, m_snap_value;
    logic [CNT_W-1:0]  m_target [NUM_CH];
    logic [CNT_W-1:0]  m_cap    [NUM_CH];
    int                m_pcnt;
    logic              m_wrap, m_snap_valid, m_irq;
    logic [NUM_CH-1:0] m_armed, m_hit, m_cap_valid, m_cap_ovr;
    logic [NUM_CH-1:0] m_hist[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    task automatic model_edge();
        logic             tick, upd, hit, edge_c;
        logic [CNT_W-1:0] nc, v, p;
        int               n;
        if (rst) begin
            m_count = '0; m_pcnt = 0; m_wrap = 1'b0; m_irq = 1'b0;
            m_snap_value = '0; m_snap_valid = 1'b0;
            m_armed = '0; m_hit = '0; m_cap_valid = '0; m_cap_ovr = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_target[c] = '0;
                m_cap[c]    = '0;
            end
            m_hist.delete();
        end else begin
            tick = bus.en && (m_pcnt >= int'(bus.prescale));
            upd  = bus.load_valid || tick;
            nc   = bus.load_valid ? bus.load_value : CNT_W'(m_count + 1);
            m_irq = |(m_hit | m_cap_valid);
            n = m_hist.size();
            for (int c = 0; c < NUM_CH; c++) begin
                v   = bus.cmp_value[c*CNT_W +: CNT_W];
                p   = bus.cmp_period[c*CNT_W +: CNT_W];
                hit = m_armed[c] && upd && (nc == m_target[c])
                      && !bus.cmp_arm[c] && !bus.cmp_disarm[c];
                if (bus.cmp_arm[c]) begin
                    m_target[c] = v; m_armed[c] = 1'b1;
                end else if (bus.cmp_disarm[c]) begin
                    m_armed[c] = 1'b0;
                end else if (hit) begin
                    if (p != 0) m_target[c] = CNT_W'(m_target[c] + p);
                    else        m_armed[c]  = 1'b0;
                end
                if (hit) m_hit[c] = 1'b1;
                else if (bus.hit_clr[c]) m_hit[c] = 1'b0;
                // synchronised value is the cap_in seen two edges ago
                edge_c = (n >= 3) && m_hist[n-2][c] && !m_hist[n-3][c];
                if (edge_c && (!m_cap_valid[c] || bus.cap_clr[c])) begin
                    m_cap[c] = m_count; m_cap_valid[c] = 1'b1; m_cap_ovr[c] = 1'b0;
                end else if (edge_c) begin
                    m_cap_ovr[c] = 1'b1;
                end else if (bus.cap_clr[c]) begin
                    m_cap_valid[c] = 1'b0; m_cap_ovr[c] = 1'b0;
                end
            end
            if (bus.snap_req) m_snap_value = m_count;
            m_snap_valid = bus.snap_req;
            m_wrap = !bus.load_valid && tick && (m_count == c_MAX);
            if (bus.load_valid) begin
                m_count = bus.load_value; m_pcnt = 0;
            end else if (tick) begin
                m_count = CNT_W'(m_count + 1); m_pcnt = 0;
            end else if (bus.en) begin
                m_pcnt = m_pcnt + 1;
            end
            m_hist.push_back(bus.cap_in);
            if (m_hist.size() > 3) void'(m_hist.pop_front());
        end
    endtask

    // Inputs are set at a negedge; one step = model + push, then cross one posedge.
    task automatic step();
        exp_t e;
        if (!rst && bus.snap_req) snap_q.push_back(m_count);
        model_edge();
        e.count = m_count; e.wrap = m_wrap;
        e.snap_value = m_snap_value; e.snap_valid = m_snap_valid;
        e.armed = m_armed; e.hit = m_hit;
        for (int c = 0; c < NUM_CH; c++) e.cap_value[c*CNT_W +: CNT_W] = m_cap[c];
        e.cap_valid = m_cap_valid; e.cap_ovr = m_cap_ovr; e.irq = m_irq;
        q.push_back(e);
        @(negedge aclk);
        bus.load_valid = 1'b0; bus.snap_req = 1'b0;
        bus.cmp_arm = '0; bus.cmp_disarm = '0; bus.hit_clr = '0; bus.cap_clr = '0;
    endtask

    // Monitor: state scoreboard every cycle, snapshot scoreboard on snap_valid.
    initial begin
        exp_t e;
        forever begin
            @(posedge aclk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("count",       bus.count,       e.count);
                chk("wrap",        bus.wrap,        e.wrap);
                chk("snap_valid",  bus.snap_valid,  e.snap_valid);
                chk("cmp_armed",   bus.cmp_armed,   e.armed);
                chk("cmp_hit",     bus.cmp_hit,     e.hit);
                chk("cap_value",   bus.cap_value,   e.cap_value);
                chk("cap_valid",   bus.cap_valid,   e.cap_valid);
                chk("cap_overrun", bus.cap_overrun, e.cap_ovr);
                chk("irq",         bus.irq,         e.irq);
            end
            if (bus.snap_valid === 1'b1) begin
                if (snap_q.size() == 0) begin
                    n_total++;
                    $display("FAIL snap_unexpected: got snap_valid=1 expected no pending snapshot at %0t", $time);
                end else begin
                    chk("snap_value", bus.snap_value, snap_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [CNT_W-1:0] fresh;
        int               n_wrap;
        rst = 1'b1;
        bus.en = 1'b0; bus.prescale = '0; bus.load_valid = 1'b0; bus.load_value = '0;
        bus.snap_req = 1'b0; bus.cmp_arm = '0; bus.cmp_disarm = '0;
        bus.cmp_value = '0; bus.cmp_period = '0; bus.hit_clr = '0;
        bus.cap_in = '0; bus.cap_clr = '0;
        @(negedge aclk);
        repeat (3) step();
        chk("reset_count", bus.count, 0);
        rst = 1'b0;

        // Prescaler with a freeze while pcnt is mid-way
        bus.prescale = 4'd3; bus.en = 1'b1;
        repeat (13) step();
        chk("presc_count", bus.count, 3);
        bus.en = 1'b0;
        repeat (10) step();
        chk("presc_frozen", bus.count, 3);
        bus.en = 1'b1;
        repeat (2) step();
        chk("presc_resume_hold", bus.count, 3);
        step();
        chk("presc_resume_tick", bus.count, 4);

        // Wrap
        bus.prescale = '0; bus.load_valid = 1'b1; bus.load_value = c_MAX - 1'b1;
        step();
        n_wrap = 0;
        repeat (3) begin
            step();
            if (bus.wrap) n_wrap++;
        end
        chk("wrap_once", n_wrap, 1);
        chk("wrap_count", bus.count, 1);

        // Periodic compare on ch0 with hit_clr racing the hit at 15
        bus.load_valid = 1'b1; bus.load_value = '0; step();
        bus.cmp_value[0 +: CNT_W] = 10; bus.cmp_period[0 +: CNT_W] = 5; bus.cmp_arm[0] = 1'b1;
        step();
        repeat (25) begin
            if (m_count == 21) break;
            bus.hit_clr[0] = (m_count == 12 || m_count == 14 || m_count == 17);
            step();
            if (m_count == 15) chk("hit_beats_clr", bus.cmp_hit[0], 1);
            if (m_count == 18) chk("hit_cleared",   bus.cmp_hit[0], 0);
            if (m_count == 20) chk("hit_at_20",     bus.cmp_hit[0], 1);
        end
        chk("periodic_armed", bus.cmp_armed[0], 1);

        // One-shot on ch1, then arm at the current count
        bus.load_valid = 1'b1; bus.load_value = '0; step();
        bus.cmp_value[CNT_W +: CNT_W] = 7; bus.cmp_period[CNT_W +: CNT_W] = '0; bus.cmp_arm[1] = 1'b1;
        step();
        repeat (8) step();
        chk("oneshot_hit", bus.cmp_hit[1], 1);
        chk("oneshot_disarmed", bus.cmp_armed[1], 0);
        bus.en = 1'b0; bus.hit_clr[1] = 1'b1; step();
        bus.cmp_value[CNT_W +: CNT_W] = m_count; bus.cmp_arm[1] = 1'b1; step();
        bus.en = 1'b1;
        repeat (5) step();
        chk("arm_at_count_nohit", bus.cmp_hit[1], 0);
        bus.load_valid = 1'b1; bus.load_value = c_MAX - 5; step();
        repeat (14) step();
        chk("arm_before_rereach", bus.cmp_hit[1], 0);
        step();
        chk("arm_rereach_hit", bus.cmp_hit[1], 1);

        // Capture on ch2
        bus.load_valid = 1'b1; bus.load_value = 98; step();
        repeat (2) step();
        bus.cap_in[2] = 1'b1;
        repeat (2) step();
        chk("cap_not_yet", bus.cap_valid[2], 0);
        step();
        chk("cap_valid", bus.cap_valid[2], 1);
        chk("cap_value_102", bus.cap_value[2*CNT_W +: CNT_W], 102);
        bus.cap_in[2] = 1'b0; repeat (2) step();
        bus.cap_in[2] = 1'b1; repeat (3) step();
        chk("cap_overrun", bus.cap_overrun[2], 1);
        chk("cap_value_held", bus.cap_value[2*CNT_W +: CNT_W], 102);
        bus.cap_in[2] = 1'b0; repeat (2) step();
        bus.cap_in[2] = 1'b1; repeat (2) step();
        fresh = m_count;
        bus.cap_clr[2] = 1'b1; step();
        chk("cap_fresh_value", bus.cap_value[2*CNT_W +: CNT_W], fresh);
        chk("cap_fresh_ovr", bus.cap_overrun[2], 0);
        bus.cap_in[2] = 1'b0;

        // Snapshot, then reset with strobes held high
        bus.load_valid = 1'b1; bus.load_value = 48; step();
        repeat (2) step();
        bus.snap_req = 1'b1; step();
        chk("snap_value_50", bus.snap_value, 50);
        chk("snap_valid_pulse", bus.snap_valid, 1);
        bus.cap_in = '1; rst = 1'b1; step();
        chk("rst_count", bus.count, 0);
        chk("rst_hit", bus.cmp_hit, 0);
        rst = 1'b0;
        repeat (6) step();
        chk("no_cap_after_rst", bus.cap_valid, 0);
        bus.cap_in = '0;

        // Randomised phase
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom % 400 == 0);
            bus.en = ($urandom % 8 != 0);
            if ($urandom % 16 == 0) bus.prescale = PRESCALE_W'($urandom_range(0, 3));
            if ($urandom % 32 == 0) begin
                bus.load_valid = 1'b1;
                bus.load_value = ($urandom % 2) ? CNT_W'($urandom) : CNT_W'(c_MAX - $urandom_range(0, 20));
            end
            bus.snap_req = ($urandom % 8 == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom % 16 == 0) begin
                    bus.cmp_arm[c] = 1'b1;
                    bus.cmp_value[c*CNT_W +: CNT_W] = ($urandom % 6 == 0) ? m_count
                                                    : CNT_W'(m_count + $urandom_range(1, 40));
                    bus.cmp_period[c*CNT_W +: CNT_W] = ($urandom % 3 == 0) ? '0
                                                     : CNT_W'($urandom_range(1, 30));
                end
                bus.cmp_disarm[c] = ($urandom % 64 == 0);
                bus.hit_clr[c]    = ($urandom % 8 == 0);
                bus.cap_clr[c]    = ($urandom % 10 == 0);
                if ($urandom % 5 == 0) bus.cap_in[c] = ~bus.cap_in[c];
            end
            step();
        end
        rst = 1'b0;
        step();
        chk("queue_drain", q.size(), 0);
        chk("snap_drain", snap_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
